// File: rtl/max_pool_2x2_if.sv
// Sample stream interface for max_pool_2x2: the master drives convolution
// samples in, the slave (the pooling block) returns pooled samples and a
// frame-complete flag.
interface max_pool_2x2_if;
  logic signed [15:0] data_in;
  logic               data_valid;
  logic signed [15:0] pool_out;
  logic               pool_valid;
  logic               pool_done;

  modport master (
    output data_in,
    output data_valid,
    input  pool_out,
    input  pool_valid,
    input  pool_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output pool_out,
    output pool_valid,
    output pool_done
  );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 / stride-2 max pooling over an FMAP x FMAP row-major sample stream.
// Horizontal pairs are reduced in a pair register, even-row pair maxima are
// parked in a P-entry line buffer, and each odd-row pair maximum is combined
// with the parked value to produce one pooled sample.
// For odd FMAP the last column and the last row are consumed but ignored.
// Build option: define POOL_RELU_EN to clamp negative pooled results to 0;
// timing and handshake are the same in both builds.
module max_pool_2x2 #(
  parameter int FMAP = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  max_pool_2x2_if.slave   bus
);

  localparam int P  = FMAP / 2;
  localparam int CW = (FMAP > 2) ? $clog2(FMAP) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [CW-1:0] LAST  = CW'(FMAP - 1);
  // One bit wider than the counters so 2P still fits when FMAP is a power of two
  localparam logic [CW:0]   TWO_P = (CW + 1)'(2 * P);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_reg;
  logic [CW-1:0]      col_reg;
  logic [CW-1:0]      row_reg;
  logic signed [15:0] pair_reg;
  logic signed [15:0] pool_out_reg;
  logic               pool_valid_reg;
  logic               pool_done_reg;
  logic signed [15:0] line_buf [P];

  logic               accept;
  logic               last_sample;
  logic               col_in;
  logic               row_in;
  logic [CW-1:0]      col_half;
  logic [PW-1:0]      buf_idx;
  logic signed [15:0] pair_max;
  logic signed [15:0] pooled;
  logic signed [15:0] pool_res;

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Sample qualification, window position decode and the two max stages
  always_comb begin
    accept      = bus.data_valid && !clr && (state_reg != ST_DONE);
    last_sample = (row_reg == LAST) && (col_reg == LAST);
    col_in      = {1'b0, col_reg} < TWO_P;
    row_in      = {1'b0, row_reg} < TWO_P;
    col_half    = col_reg >> 1;
    buf_idx     = col_half[PW-1:0];
    pair_max    = smax(pair_reg, bus.data_in);
    pooled      = smax(line_buf[buf_idx], pair_max);
`ifdef POOL_RELU_EN
    pool_res    = pooled[15] ? 16'sd0 : pooled;
`else
    pool_res    = pooled;
`endif
  end

  // Frame FSM, row/col counters, pair register and the registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      pair_reg       <= '0;
      pool_out_reg   <= '0;
      pool_valid_reg <= 1'b0;
      pool_done_reg  <= 1'b0;
    end else if (clr) begin
      state_reg      <= ST_IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      pair_reg       <= '0;
      pool_out_reg   <= '0;
      pool_valid_reg <= 1'b0;
      pool_done_reg  <= 1'b0;
    end else begin
      pool_valid_reg <= 1'b0;
      // Done follows DONE by one cycle, which also places it after the
      // final pool_valid pulse when the last sample is itself pooled
      pool_done_reg  <= (state_reg == ST_DONE);
      if (accept) begin
        state_reg <= last_sample ? ST_DONE : ST_RUN;
        if (col_reg == LAST) begin
          col_reg <= '0;
          row_reg <= last_sample ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
        if (col_in && !col_reg[0]) begin
          pair_reg <= bus.data_in;
        end
        if (col_in && col_reg[0] && row_in && row_reg[0]) begin
          pool_out_reg   <= pool_res;
          pool_valid_reg <= 1'b1;
        end
      end
    end
  end

  // Line buffer write of even-row pair maxima; contents are always written
  // before being read within a frame, so no reset is needed
  always_ff @(posedge clk) begin
    if (rst_n && accept && col_in && col_reg[0] && row_in && !row_reg[0]) begin
      line_buf[buf_idx] <= pair_max;
    end
  end

  assign bus.pool_out   = pool_out_reg;
  assign bus.pool_valid = pool_valid_reg;
  assign bus.pool_done  = pool_done_reg;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: one instance with FMAP=4 and one with
// FMAP=5, driven with directed and $urandom frames and compared against a
// plain-arithmetic pooling model of each whole frame.
module tb_max_pool_2x2;

  logic clk = 1'b0;
  logic rst_n;
  logic clr4;
  logic clr5;

  always #5 clk = ~clk;

  max_pool_2x2_if if4 ();
  max_pool_2x2_if if5 ();

  max_pool_2x2 #(.FMAP(4)) dut4 (.clk(clk), .rst_n(rst_n), .clr(clr4), .bus(if4));
  max_pool_2x2 #(.FMAP(5)) dut5 (.clk(clk), .rst_n(rst_n), .clr(clr5), .bus(if5));

  int total = 0;
  int bad   = 0;
  int frame_q[$];
  int exp_q[$];
  int mon4[$];
  int mon5[$];

  // Collect every pooled sample, sampled mid-cycle
  always @(negedge clk) begin
    if (if4.pool_valid) mon4.push_back(int'(if4.pool_out));
    if (if5.pool_valid) mon5.push_back(int'(if5.pool_out));
  end

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int get_pv(input int sel);
    if (sel == 0) return int'(if4.pool_valid);
    return int'(if5.pool_valid);
  endfunction

  function automatic int get_done(input int sel);
    if (sel == 0) return int'(if4.pool_done);
    return int'(if5.pool_done);
  endfunction

  function automatic int get_out(input int sel);
    if (sel == 0) return int'(if4.pool_out);
    return int'(if5.pool_out);
  endfunction

  // Reference: max of each 2x2 window of the frame, row-major output order
  function automatic void model(input int fm);
    int p;
    int m;
    p = fm / 2;
    exp_q.delete();
    for (int r = 0; r < p; r++) begin
      for (int c = 0; c < p; c++) begin
        m = frame_q[2*r*fm + 2*c];
        if (frame_q[2*r*fm + 2*c + 1] > m) m = frame_q[2*r*fm + 2*c + 1];
        if (frame_q[(2*r+1)*fm + 2*c] > m) m = frame_q[(2*r+1)*fm + 2*c];
        if (frame_q[(2*r+1)*fm + 2*c + 1] > m) m = frame_q[(2*r+1)*fm + 2*c + 1];
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        exp_q.push_back(m);
      end
    end
  endfunction

  function automatic void gen_seq(input int fm);
    frame_q.delete();
    for (int i = 1; i <= fm*fm; i++) frame_q.push_back(i);
  endfunction

  function automatic void gen_rand(input int fm, input int lo, input int hi);
    frame_q.delete();
    for (int i = 0; i < fm*fm; i++)
      frame_q.push_back(lo + int'($urandom_range(0, hi - lo)));
  endfunction

  // One clock of stimulus; returns at posedge + 1
  task automatic drive(input int sel, input bit v, input int d);
    if (sel == 0) begin
      if4.data_valid = v;
      if4.data_in    = 16'(d);
    end else begin
      if5.data_valid = v;
      if5.data_in    = 16'(d);
    end
    @(posedge clk);
    #1;
    if4.data_valid = 1'b0;
    if5.data_valid = 1'b0;
  endtask

  task automatic pulse_clr(input int sel, input bit v, input int d);
    if (sel == 0) begin
      clr4 = 1'b1; if4.data_valid = v; if4.data_in = 16'(d);
    end else begin
      clr5 = 1'b1; if5.data_valid = v; if5.data_in = 16'(d);
    end
    @(posedge clk);
    #1;
    clr4 = 1'b0;
    clr5 = 1'b0;
    if4.data_valid = 1'b0;
    if5.data_valid = 1'b0;
  endtask

  // Feed frame_q as one full frame, checking pulse placement and done timing
  task automatic feed(input int sel, input bit bubbles, input string tag);
    int fm;
    int p;
    int n;
    int r;
    int c;
    int w;
    fm = (sel == 0) ? 4 : 5;
    p  = fm / 2;
    n  = fm * fm;
    for (int k = 0; k < n; k++) begin
      if (bubbles) begin
        while ($urandom_range(0, 2) == 0) begin
          drive(sel, 1'b0, int'($urandom_range(0, 65535)));
          check_val({tag, "_bubble_pv"}, get_pv(sel), 0);
        end
      end
      if (k == n - 1) check_val({tag, "_done_early"}, get_done(sel), 0);
      drive(sel, 1'b1, frame_q[k]);
      r = k / fm;
      c = k % fm;
      check_val({tag, "_pv"}, get_pv(sel),
                ((r % 2 == 1) && (c % 2 == 1) && (r < 2*p) && (c < 2*p)) ? 1 : 0);
    end
    check_val({tag, "_done_lat"}, get_done(sel), 0);
    w = 0;
    while (!get_done(sel) && w < 4) begin
      drive(sel, 1'b0, 0);
      w++;
    end
    check_val({tag, "_done"}, get_done(sel), 1);
  endtask

  task automatic compare(input int sel, input string tag);
    int got[$];
    model((sel == 0) ? 4 : 5);
    if (sel == 0) got = mon4; else got = mon5;
    check_val({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_val({tag, "_out"}, got[i], exp_q[i]);
  endtask

  task automatic check_idle(input int sel, input string tag);
    check_val({tag, "_out0"}, get_out(sel), 0);
    check_val({tag, "_pv0"}, get_pv(sel), 0);
    check_val({tag, "_done0"}, get_done(sel), 0);
  endtask

  initial begin
    int s1_lit[4];
    int s2_lit[4];
    int held;
    int cnt;
    s1_lit = '{6, 8, 14, 16};
    s2_lit = '{7, 9, 17, 19};

    rst_n = 1'b0;
    clr4 = 1'b0;
    clr5 = 1'b0;
    if4.data_valid = 1'b0; if4.data_in = '0;
    if5.data_valid = 1'b0; if5.data_in = '0;
    #23;
    check_idle(0, "rst4");
    check_idle(1, "rst5");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contiguous 1..16 on FMAP=4
    gen_seq(4); mon4.delete();
    feed(0, 1'b0, "s1");
    compare(0, "s1");
    for (int i = 0; i < 4 && i < mon4.size(); i++) check_val("s1_lit", mon4[i], s1_lit[i]);

    // DONE ignores data_valid
    cnt  = mon4.size();
    held = get_out(0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, int'($urandom_range(0, 32767)));
      check_val("done_hold_pv", get_pv(0), 0);
    end
    check_val("done_hold_cnt", mon4.size(), cnt);
    check_val("done_hold_out", get_out(0), held);
    check_val("done_hold_done", get_done(0), 1);
    pulse_clr(0, 1'b0, 0);
    check_idle(0, "clr_after_done");

    // 1..25 on FMAP=5: last column and row discarded
    gen_seq(5); mon5.delete();
    feed(1, 1'b0, "s2");
    compare(1, "s2");
    for (int i = 0; i < 4 && i < mon5.size(); i++) check_val("s2_lit", mon5[i], s2_lit[i]);
    pulse_clr(1, 1'b0, 0);

    // All-negative frames
    gen_rand(4, -100, -1); mon4.delete();
    feed(0, 1'b0, "s3a");
    compare(0, "s3a");
    pulse_clr(0, 1'b0, 0);
    gen_rand(5, -100, -1); mon5.delete();
    feed(1, 1'b1, "s3b");
    compare(1, "s3b");
    pulse_clr(1, 1'b0, 0);

    // Bubbles on the 1..16 frame
    gen_seq(4); mon4.delete();
    feed(0, 1'b1, "s4");
    compare(0, "s4");
    pulse_clr(0, 1'b0, 0);

    // clr after 7 samples, clr colliding with a valid sample, then replay
    gen_seq(4);
    for (int k = 0; k < 7; k++) drive(0, 1'b1, frame_q[k]);
    pulse_clr(0, 1'b1, 999);
    check_idle(0, "s5_clr");
    mon4.delete();
    feed(0, 1'b0, "s5");
    compare(0, "s5");
    pulse_clr(0, 1'b0, 0);

    // Async reset mid-cycle in RUN
    gen_seq(4);
    for (int k = 0; k < 8; k++) drive(0, 1'b1, frame_q[k]);
    check_val("s6_pre_pv", get_pv(0), 1);
    check_val("s6_pre_out", get_out(0), 8);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle(0, "s6_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon4.delete();
    feed(0, 1'b0, "s6");
    compare(0, "s6");
    pulse_clr(0, 1'b0, 0);
    pulse_clr(1, 1'b0, 0);

    // Random full-range frames with bubbles
    for (int t = 0; t < 3; t++) begin
      gen_rand(4, -32768, 32767); mon4.delete();
      feed(0, 1'b1, "rnd4");
      compare(0, "rnd4");
      pulse_clr(0, 1'b0, 0);
      gen_rand(5, -32768, 32767); mon5.delete();
      feed(1, 1'b1, "rnd5");
      compare(1, "rnd5");
      pulse_clr(1, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
